vga_sync_controller: RTL and testbench



---
 rtl/vga_sync_controller.sv | 86 ++++++++
 tb/tb_vga_sync_controller.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vga_sync_controller.sv
// rtl/vga_sync_controller.sv - 640x480@60 VGA timing generator: pixel divider, x/y counters, registered syncs and strobes
module vga_sync_controller #(
   parameter int CLK_DIV      = 4,
   parameter int H_DISPLAY    = 640,
   parameter int H_FRONT      = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BACK       = 48,
   parameter int V_DISPLAY    = 480,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 33,
   parameter int SCREEN_WIDTH = 10
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   output logic                    p_tick,
   output logic [SCREEN_WIDTH-1:0] x,
   output logic [SCREEN_WIDTH-1:0] y,
   output logic                    video_on,
   output logic                    hsync,
   output logic                    vsync,
   output logic                    line_start,
   output logic                    frame_start
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0]        DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [SCREEN_WIDTH-1:0] H_MAX    = SCREEN_WIDTH'(H_TOTAL - 1);
   localparam logic [SCREEN_WIDTH-1:0] V_MAX    = SCREEN_WIDTH'(V_TOTAL - 1);
   localparam logic [SCREEN_WIDTH-1:0] H_VIS    = SCREEN_WIDTH'(H_DISPLAY);
   localparam logic [SCREEN_WIDTH-1:0] V_VIS    = SCREEN_WIDTH'(V_DISPLAY);
   localparam logic [SCREEN_WIDTH-1:0] HS_START = SCREEN_WIDTH'(H_DISPLAY + H_FRONT);
   localparam logic [SCREEN_WIDTH-1:0] HS_END   = SCREEN_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [SCREEN_WIDTH-1:0] VS_START = SCREEN_WIDTH'(V_DISPLAY + V_FRONT);
   localparam logic [SCREEN_WIDTH-1:0] VS_END   = SCREEN_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [DIV_W-1:0]        div_cnt;
   logic [SCREEN_WIDTH-1:0] x_next;
   logic [SCREEN_WIDTH-1:0] y_next;
   logic                    x_wrap;
   logic                    y_wrap;

   // >= rather than == so an out-of-range count can never run past the wrap point
   always_comb begin
      x_wrap = (x >= H_MAX);
      y_wrap = (y >= V_MAX);
      x_next = x_wrap ? '0 : x + 1'b1;
      y_next = y;
      if (x_wrap) begin
         y_next = y_wrap ? '0 : y + 1'b1;
      end
   end

   // Decoded outputs only move on pixel ticks, so they track the x/y being presented
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         div_cnt     <= '0;
         p_tick      <= 1'b0;
         x           <= '0;
         y           <= '0;
         video_on    <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div_cnt     <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
         p_tick      <= (div_cnt == DIV_MAX);
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (p_tick) begin
            x           <= x_next;
            y           <= y_next;
            video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
            hsync       <= !((x_next >= HS_START) && (x_next < HS_END));
            vsync       <= !((y_next >= VS_START) && (y_next < VS_END));
            line_start  <= x_wrap;
            frame_start <= x_wrap && y_wrap;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_controller.sv
// tb/tb_vga_sync_controller.sv - randomized-reset bench comparing three timing configurations against an arithmetic model
module tb_vga_sync_controller;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 sys_clk = ~sys_clk;

   logic       a_tick, a_vo, a_hs, a_vs, a_ls, a_fs;
   logic [9:0] a_x, a_y;
   logic       b_tick, b_vo, b_hs, b_vs, b_ls, b_fs;
   logic [3:0] b_x, b_y;
   logic       c_tick, c_vo, c_hs, c_vs, c_ls, c_fs;
   logic [3:0] c_x, c_y;

   vga_sync_controller dut_a (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .p_tick(a_tick), .x(a_x), .y(a_y),
      .video_on(a_vo), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs)
   );

   vga_sync_controller #(
      .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SCREEN_WIDTH(4)
   ) dut_b (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .p_tick(b_tick), .x(b_x), .y(b_y),
      .video_on(b_vo), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs)
   );

   vga_sync_controller #(
      .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SCREEN_WIDTH(4)
   ) dut_c (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .p_tick(c_tick), .x(c_x), .y(c_y),
      .video_on(c_vo), .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Expected {p_tick, x, y, video_on, hsync, vsync, line_start, frame_start}
   // after t clock edges since reset release, from pixel arithmetic alone.
   function automatic logic [31:0] model(input int t, input int d,
                                         input int hd, input int hf, input int hsw, input int hb,
                                         input int vd, input int vf, input int vsw, input int vb);
      int ht, vt, n, pos, xx, yy;
      logic pt, vo, hs, vs, ls, fs;
      ht  = hd + hf + hsw + hb;
      vt  = vd + vf + vsw + vb;
      pt  = (t > 0) && (t % d == 0);
      n   = (t > 0) ? (t - 1) / d : 0;
      pos = n % (ht * vt);
      xx  = pos % ht;
      yy  = pos / ht;
      if (n == 0) begin
         vo = 1'b0; hs = 1'b1; vs = 1'b1; ls = 1'b0; fs = 1'b0;
      end else begin
         vo = (xx < hd) && (yy < vd);
         hs = !((xx >= hd + hf) && (xx < hd + hf + hsw));
         vs = !((yy >= vd + vf) && (yy < vd + vf + vsw));
         ls = ((t - 1) % d == 0) && (xx == 0);
         fs = ls && (yy == 0);
      end
      return {6'd0, pt, 10'(xx), 10'(yy), vo, hs, vs, ls, fs};
   endfunction

   function automatic logic [31:0] pack(input logic pt, input logic [9:0] xx, input logic [9:0] yy,
                                        input logic vo, input logic hs, input logic vs,
                                        input logic ls, input logic fs);
      return {6'd0, pt, xx, yy, vo, hs, vs, ls, fs};
   endfunction

   int t = 0;
   always @(posedge sys_clk) begin
      if (sys_rst) t <= 0;
      else         t <= t + 1;
   end

   logic run = 1'b0;
   int   cyc = 0;
   int   last_la = -1, last_fb = -1, last_fc = -1;
   int   te;

   always @(negedge sys_clk) begin
      if (run) begin
         cyc++;
         te = sys_rst ? 0 : t;
         check("a_outputs", pack(a_tick, a_x, a_y, a_vo, a_hs, a_vs, a_ls, a_fs),
               model(te, 4, 640, 16, 96, 48, 480, 10, 2, 33));
         check("b_outputs", pack(b_tick, {6'd0, b_x}, {6'd0, b_y}, b_vo, b_hs, b_vs, b_ls, b_fs),
               model(te, 3, 8, 2, 3, 2, 6, 1, 2, 2));
         check("c_outputs", pack(c_tick, {6'd0, c_x}, {6'd0, c_y}, c_vo, c_hs, c_vs, c_ls, c_fs),
               model(te, 1, 8, 2, 3, 2, 6, 1, 2, 2));
         if (sys_rst) begin
            last_la = -1; last_fb = -1; last_fc = -1;
         end else begin
            if (a_ls) begin
               if (last_la >= 0) check("a_line_period", 32'(cyc - last_la), 32'd3200);
               last_la = cyc;
            end
            if (b_fs) begin
               if (last_fb >= 0) check("b_frame_period", 32'(cyc - last_fb), 32'd495);
               last_fb = cyc;
            end
            if (c_fs) begin
               if (last_fc >= 0) check("c_frame_period", 32'(cyc - last_fc), 32'd165);
               last_fc = cyc;
            end
         end
      end
   end

   initial begin
      sys_rst = 1'b1;
      run = 1'b1;
      repeat (3) @(posedge sys_clk);
      #2 sys_rst = 1'b0;
      repeat (3 * 3200 + 50) @(posedge sys_clk);
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(1, 2000)) @(posedge sys_clk);
         #($urandom_range(1, 3)) sys_rst = 1'b1;
         repeat ($urandom_range(1, 4)) @(posedge sys_clk);
         #2 sys_rst = 1'b0;
      end
      repeat (1200) @(posedge sys_clk);
      @(negedge sys_clk);
      run = 1'b0;
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
